// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checker: FSM state encodings and the N_IN ceiling.
package gate_sweep_checker_pkg;

   localparam int MAX_N_IN = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Per-vector settle timer: counts while enabled and strobes sample_o on the
// last of SETTLE cycles, then wraps so the next vector starts at zero.
module sweep_settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic sample_o
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] TC = CW'(SETTLE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign sample_o = en_i && (cnt_q == TC);

   always_comb begin
      cnt_d = '0;
      if (en_i && !sample_o) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweep of an external N_IN-input gate against TRUTH.
// Optional SWEEP_STOP_ON_FAIL_EN: end the sweep on the first mismatching sample.
//
// state    | meaning
// ST_IDLE  | waiting for start; results from the last sweep held
// ST_SWEEP | driving stim, sampling dut_x once per SETTLE cycles
// ST_DONE  | one-cycle completion pulse, pass valid
module gate_sweep_checker
   import gate_sweep_checker_pkg::*;
#(
   parameter int                   N_IN   = 3,
   parameter logic [2**N_IN-1:0]   TRUTH  = 8'hE8,
   parameter int                   SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic            dut_x,
   output logic [N_IN-1:0] stim,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic [N_IN-1:0] first_fail,
   output logic            fail_valid
);

   if (N_IN < 1 || N_IN > MAX_N_IN) begin : g_bad_n_in
      $error("gate_sweep_checker: N_IN out of range");
   end

   localparam logic [N_IN-1:0] STIM_LAST = '1;

   state_e          state_q, state_d;
   logic [N_IN-1:0] stim_q, stim_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] ff_q, ff_d;
   logic            fv_q, fv_d;
   logic            pass_q, pass_d;
   logic            sample;
   logic            mismatch;
   logic            stop_now;

   sweep_settle_timer #(.SETTLE(SETTLE)) u_settle (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (state_q == ST_SWEEP),
      .sample_o (sample)
   );

   assign mismatch = (dut_x != TRUTH[stim_q]);

   always_comb begin
      state_d  = state_q;
      stim_d   = stim_q;
      err_d    = err_q;
      ff_d     = ff_q;
      fv_d     = fv_q;
      pass_d   = pass_q;
      stop_now = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_SWEEP;
               stim_d  = '0;
               err_d   = '0;
               ff_d    = '0;
               fv_d    = 1'b0;
               pass_d  = 1'b0;
            end
         end
         ST_SWEEP: begin
            // abort wins over a coincident sample, which is simply dropped
            if (abort) begin
               state_d = ST_IDLE;
               stim_d  = '0;
            end else if (sample) begin
               if (mismatch) begin
                  err_d = err_q + (N_IN+1)'(1);
                  if (!fv_q) begin
                     ff_d = stim_q;
                     fv_d = 1'b1;
                  end
`ifdef SWEEP_STOP_ON_FAIL_EN
                  stop_now = 1'b1;
`endif
               end
               if (stop_now || stim_q == STIM_LAST) begin
                  state_d = ST_DONE;
                  pass_d  = (err_d == '0);
               end else begin
                  stim_d = stim_q + N_IN'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            stim_d  = '0;
         end
         default: begin
            state_d = ST_IDLE;
            stim_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         stim_q  <= '0;
         err_q   <= '0;
         ff_q    <= '0;
         fv_q    <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         fv_q    <= fv_d;
         pass_q  <= pass_d;
      end
   end

   assign stim       = stim_q;
   assign busy       = (state_q == ST_SWEEP);
   assign done       = (state_q == ST_DONE);
   assign pass       = pass_q;
   assign err_cnt    = err_q;
   assign first_fail = ff_q;
   assign fail_valid = fv_q;

endmodule
